ir_cmd_mapper: RTL and testbench

- Sits directly downstream of the NEC IR receiver in the Tetris design.
- Consumes the receiver's validated 32-bit frame and its level-type ready flag.
- Checks the remote custom code and maps the key byte to a 3-bit game command.
- Applies a per-key lockout so a single keypress cannot trigger a command twice, then buffers commands in a 4-deep FIFO with a valid/ready handshake to the game controller.

---
 rtl/ir_cmd_mapper.sv | 196 +++++++++++++++++++
 tb/tb_ir_cmd_mapper.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_cmd_mapper.sv
// ir_cmd_mapper
//   Sits between the NEC IR receiver and the Tetris game controller.
//   It checks the remote's custom code and maps the key byte to a 3-bit game command.
//   A per-key lockout stops one held keypress from firing a non-repeatable
//   command twice. Accepted commands go into a 4-deep show-ahead FIFO with a
//   valid/ready handshake.
//
// Ports
//   iCLK         in   1   system clock (50 MHz)
//   iRST_n       in   1   asynchronous active-low reset
//   iDATA_READY  in   1   receiver frame-valid level (may stay high for long)
//   iDATA        in  32   frame: [15:0] custom code, [23:16] key, [31:24] ~key
//   oCMD         out  3   FIFO head: 1 LEFT 2 RIGHT 3 ROTATE 4 SOFT 5 HARD
//                         6 PAUSE 7 RESTART; 0 when empty
//   oCMD_VALID   out  1   FIFO not empty
//   iCMD_READY   in   1   consumer takes the head when high with oCMD_VALID
//   oOVERFLOW    out  1   one-cycle pulse: command dropped, FIFO full
//   oADDR_ERR    out  1   one-cycle pulse: frame dropped, custom code mismatch
//   oLAST_KEY    out  8   key byte of the last accepted command
module ir_cmd_mapper #(
    parameter logic [15:0] CUSTOM_CODE = 16'h6B86,
    parameter bit          CHECK_ADDR  = 1'b1,
    parameter logic [7:0]  KEY_LEFT    = 8'h14,
    parameter logic [7:0]  KEY_RIGHT   = 8'h18,
    parameter logic [7:0]  KEY_ROTATE  = 8'h1A,
    parameter logic [7:0]  KEY_SOFT    = 8'h1E,
    parameter logic [7:0]  KEY_HARD    = 8'h15,
    parameter logic [7:0]  KEY_PAUSE   = 8'h16,
    parameter logic [7:0]  KEY_RESTART = 8'h12,
    parameter int unsigned LOCKOUT_CYC = 10000000
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iDATA_READY,
    input  logic [31:0] iDATA,
    output logic [2:0]  oCMD,
    output logic        oCMD_VALID,
    input  logic        iCMD_READY,
    output logic        oOVERFLOW,
    output logic        oADDR_ERR,
    output logic [7:0]  oLAST_KEY
);

    localparam logic [23:0] LOCK_MAX = 24'(LOCKOUT_CYC);

    localparam logic [2:0] CMD_NONE  = 3'd0;
    localparam logic [2:0] CMD_LEFT  = 3'd1;
    localparam logic [2:0] CMD_RIGHT = 3'd2;
    localparam logic [2:0] CMD_SOFT  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_PUSH
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        ready_q;
    logic [23:0] frame_q;
    logic [2:0]  cmd_q;
    logic [23:0] lock_cnt;
    logic [7:0]  last_key;

    logic [2:0]  cmd_lookup;
    logic        take_frame;
    logic        load_cmd;
    logic        push_req;
    logic        addr_err;
    logic        locked;
    logic        push;
    logic        pop;

    logic [2:0]  fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    // The inverted key byte is not checked; the receiver already validated it.
    logic        unused_inv_key;
    assign unused_inv_key = ^iDATA[31:24];

    // Key byte -> command; first match wins if parameters ever collide.
    always_comb begin
        cmd_lookup = CMD_NONE;
        if      (frame_q[23:16] == KEY_LEFT)    cmd_lookup = 3'd1;
        else if (frame_q[23:16] == KEY_RIGHT)   cmd_lookup = 3'd2;
        else if (frame_q[23:16] == KEY_ROTATE)  cmd_lookup = 3'd3;
        else if (frame_q[23:16] == KEY_SOFT)    cmd_lookup = 3'd4;
        else if (frame_q[23:16] == KEY_HARD)    cmd_lookup = 3'd5;
        else if (frame_q[23:16] == KEY_PAUSE)   cmd_lookup = 3'd6;
        else if (frame_q[23:16] == KEY_RESTART) cmd_lookup = 3'd7;
    end

    // Movement keys may repeat freely; everything else is held off while
    // the same key is still inside its lockout window.
    always_comb begin
        locked = 1'b0;
        if (cmd_q != CMD_LEFT && cmd_q != CMD_RIGHT && cmd_q != CMD_SOFT)
            locked = (frame_q[23:16] == last_key) && (lock_cnt < LOCK_MAX);
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) state <= ST_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        take_frame = 1'b0;
        load_cmd   = 1'b0;
        push_req   = 1'b0;
        addr_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (iDATA_READY && !ready_q) begin
                    take_frame = 1'b1;
                    state_nx   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (CHECK_ADDR && frame_q[15:0] != CUSTOM_CODE) begin
                    addr_err = 1'b1;
                    state_nx = ST_IDLE;
                end else if (cmd_lookup != CMD_NONE) begin
                    load_cmd = 1'b1;
                    state_nx = ST_PUSH;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_PUSH: begin
                push_req = !locked;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign empty = (count == 3'd0);
    assign full  = (count == 3'd4);
    assign pop   = !empty && iCMD_READY;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push  = push_req && (!full || pop);

    assign oOVERFLOW  = push_req && full && !pop;
    assign oADDR_ERR  = addr_err;
    assign oCMD_VALID = !empty;
    assign oCMD       = empty ? CMD_NONE : fifo_mem[rd_ptr];
    assign oLAST_KEY  = last_key;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            ready_q  <= 1'b0;
            frame_q  <= '0;
            cmd_q    <= '0;
            last_key <= '0;
            lock_cnt <= LOCK_MAX;
        end else begin
            ready_q <= iDATA_READY;
            if (take_frame) frame_q <= iDATA[23:0];
            if (load_cmd)   cmd_q   <= cmd_lookup;
            if (push) begin
                last_key <= frame_q[23:16];
                lock_cnt <= '0;
            end else if (lock_cnt < LOCK_MAX) begin
                lock_cnt <= lock_cnt + 24'd1;
            end
        end
    end

    // Storage is not reset; oCMD is forced to 0 whenever the FIFO is empty.
    always_ff @(posedge iCLK) begin
        if (push) fifo_mem[wr_ptr] <= cmd_q;
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_cmd_mapper.sv
// tb_ir_cmd_mapper
//   Bench for ir_cmd_mapper. A behavioural model keeps the expected command
//   queue, last key and lockout timing as plain cycle arithmetic. Directed
//   tasks cover the scenarios of interest and a randomized task compares every
//   output cycle by cycle.
//
// Ports: none (top-level bench).
module tb_ir_cmd_mapper;

    localparam int unsigned LOCK = 2000;
    localparam logic [15:0] CODE = 16'h6B86;
    localparam logic [7:0]  K_LEFT = 8'h14, K_RIGHT = 8'h18, K_ROT = 8'h1A,
                            K_SOFT = 8'h1E, K_HARD = 8'h15, K_PAUSE = 8'h16,
                            K_RESTART = 8'h12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_ready = 1'b0;
    logic [31:0] data = '0;
    logic        cmd_ready = 1'b0;
    logic [2:0]  cmd, na_cmd;
    logic        cmd_valid, na_cmd_valid;
    logic        ovf, na_ovf;
    logic        addr_err, na_addr_err;
    logic [7:0]  last_key, na_last_key;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ir_cmd_mapper #(.LOCKOUT_CYC(LOCK)) u_dut (
        .iCLK(clk), .iRST_n(rst_n), .iDATA_READY(data_ready), .iDATA(data),
        .oCMD(cmd), .oCMD_VALID(cmd_valid), .iCMD_READY(cmd_ready),
        .oOVERFLOW(ovf), .oADDR_ERR(addr_err), .oLAST_KEY(last_key)
    );

    ir_cmd_mapper #(.CHECK_ADDR(1'b0), .LOCKOUT_CYC(LOCK)) u_dut_na (
        .iCLK(clk), .iRST_n(rst_n), .iDATA_READY(data_ready), .iDATA(data),
        .oCMD(na_cmd), .oCMD_VALID(na_cmd_valid), .iCMD_READY(cmd_ready),
        .oOVERFLOW(na_ovf), .oADDR_ERR(na_addr_err), .oLAST_KEY(na_last_key)
    );

    // ---------------- behavioural model ----------------
    logic [2:0]  mq[$];
    logic [7:0]  m_last;
    longint      m_acc_cyc;
    logic        m_prev_rdy;
    logic        m_have_frame;
    longint      m_take_cyc;
    logic [31:0] m_frame;
    longint      cyc = 0;

    logic [2:0] exp_cmd, act_cmd;
    logic       exp_valid, act_valid, exp_ovf, act_ovf, exp_err, act_err;
    logic [7:0] exp_last, act_last;
    logic       act_na_valid;
    logic [2:0] act_na_cmd;

    logic [2:0] pop_log[$];
    int         ovf_count, err_count, na_err_count;

    function automatic logic [2:0] map_key(input logic [7:0] k);
        case (k)
            K_LEFT:    return 3'd1;
            K_RIGHT:   return 3'd2;
            K_ROT:     return 3'd3;
            K_SOFT:    return 3'd4;
            K_HARD:    return 3'd5;
            K_PAUSE:   return 3'd6;
            K_RESTART: return 3'd7;
            default:   return 3'd0;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        m_last       = 8'h00;
        m_acc_cyc    = -longint'(LOCK) - 10;
        m_prev_rdy   = 1'b0;
        m_have_frame = 1'b0;
    endtask

    task automatic clear_logs();
        pop_log.delete();
        ovf_count = 0;
        err_count = 0;
        na_err_count = 0;
    endtask

    // One clock cycle: predict outputs at mid-cycle, sample the DUT, then
    // advance the model by what happens at the closing edge.
    task automatic tick();
        logic [2:0] mcmd;
        logic [7:0] key;
        logic       do_push, do_pop, rep;
        @(negedge clk);
        exp_valid = (mq.size() != 0);
        exp_cmd   = exp_valid ? mq[0] : 3'd0;
        exp_last  = m_last;
        exp_err   = 1'b0;
        exp_ovf   = 1'b0;
        do_push   = 1'b0;
        key       = m_frame[23:16];
        mcmd      = map_key(key);
        if (m_have_frame && m_take_cyc + 1 == cyc && m_frame[15:0] != CODE)
            exp_err = 1'b1;
        if (m_have_frame && m_take_cyc + 2 == cyc && m_frame[15:0] == CODE && mcmd != 3'd0) begin
            rep = (mcmd == 3'd1 || mcmd == 3'd2 || mcmd == 3'd4);
            do_push = rep || key != m_last || (cyc - m_acc_cyc - 1 >= longint'(LOCK));
        end
        do_pop = exp_valid && cmd_ready;
        if (do_push && mq.size() == 4 && !do_pop) begin
            exp_ovf = 1'b1;
            do_push = 1'b0;
        end
        act_cmd = cmd; act_valid = cmd_valid; act_ovf = ovf;
        act_err = addr_err; act_last = last_key;
        act_na_valid = na_cmd_valid; act_na_cmd = na_cmd;
        if (cmd_valid && cmd_ready) pop_log.push_back(cmd);
        if (ovf) ovf_count++;
        if (addr_err) err_count++;
        if (na_addr_err) na_err_count++;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            mq.push_back(mcmd);
            m_last    = key;
            m_acc_cyc = cyc;
        end
        if (data_ready && !m_prev_rdy) begin
            m_have_frame = 1'b1;
            m_take_cyc   = cyc;
            m_frame      = data;
        end
        m_prev_rdy = data_ready;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        data_ready = 1'b0;
        cmd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic send(input logic [7:0] k, input int gap);
        data = {~k, k, CODE};
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        repeat (gap - 1) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++; if (cmd !== 3'd0) begin bad++; $display("FAIL reset_cmd got=%0d want=0", cmd); end
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", cmd_valid); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL reset_addr_err got=%b want=0", addr_err); end
        total++; if (last_key !== 8'h00) begin bad++; $display("FAIL reset_last_key got=%h want=00", last_key); end
        do_reset();
    endtask

    task automatic test_single_hold();
        int n_valid = 0, first = -1;
        logic [2:0] vcmd = '0;
        clear_logs();
        cmd_ready = 1'b1;
        data = 32'hEB146B86;
        data_ready = 1'b1;
        for (int i = 0; i < 510; i++) begin
            if (i == 500) data_ready = 1'b0;
            tick();
            if (act_valid) begin
                n_valid++;
                if (first < 0) begin first = i; vcmd = act_cmd; end
            end
        end
        total++; if (n_valid != 1) begin bad++; $display("FAIL hold_valid_cycles got=%0d want=1", n_valid); end
        total++; if (first != 3) begin bad++; $display("FAIL hold_latency got=%0d want=3", first); end
        total++; if (vcmd !== 3'd1) begin bad++; $display("FAIL hold_cmd got=%0d want=1", vcmd); end
        total++; if (act_last !== K_LEFT) begin bad++; $display("FAIL hold_last_key got=%h want=14", act_last); end
    endtask

    task automatic test_addr();
        int err_at = -1, na_first = -1, n_valid = 0;
        logic [2:0] na_c = '0;
        do_reset();
        clear_logs();
        cmd_ready = 1'b1;
        data = 32'hEB141234;
        data_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 1) data_ready = 1'b0;
            tick();
            if (act_err && err_at < 0) err_at = i;
            if (act_valid) n_valid++;
            if (act_na_valid && na_first < 0) begin na_first = i; na_c = act_na_cmd; end
        end
        total++; if (err_count != 1) begin bad++; $display("FAIL addr_err_pulses got=%0d want=1", err_count); end
        total++; if (err_at != 1) begin bad++; $display("FAIL addr_err_cycle got=%0d want=1", err_at); end
        total++; if (n_valid != 0) begin bad++; $display("FAIL addr_fifo_valid got=%0d want=0", n_valid); end
        total++; if (na_first != 3 || na_c !== 3'd1) begin bad++; $display("FAIL noaddr_queue got=cyc%0d cmd%0d want=cyc3 cmd1", na_first, na_c); end
        total++; if (na_err_count != 0) begin bad++; $display("FAIL noaddr_err got=%0d want=0", na_err_count); end
    endtask

    task automatic test_lockout();
        clear_logs();
        cmd_ready = 1'b1;
        send(K_ROT, 1000);
        send(K_ROT, LOCK + 10);
        send(K_ROT, 20);
        total++;
        if (pop_log.size() != 2 || pop_log[0] !== 3'd3 || pop_log[1] !== 3'd3) begin
            bad++; $display("FAIL lockout_cmds got=%p want=3,3", pop_log);
        end
    endtask

    task automatic test_repeat();
        clear_logs();
        cmd_ready = 1'b1;
        send(K_LEFT, 1000);
        send(K_LEFT, 20);
        total++;
        if (pop_log.size() != 2 || pop_log[0] !== 3'd1 || pop_log[1] !== 3'd1) begin
            bad++; $display("FAIL repeat_cmds got=%p want=1,1", pop_log);
        end
    endtask

    task automatic test_overflow();
        int drop_cyc = -1;
        clear_logs();
        cmd_ready = 1'b0;
        send(K_RIGHT, 10);
        send(K_ROT, 10);
        send(K_SOFT, 10);
        send(K_HARD, 10);
        send(K_PAUSE, 10);
        total++; if (ovf_count != 1) begin bad++; $display("FAIL ovf_pulses got=%0d want=1", ovf_count); end
        total++; if (act_last !== K_HARD) begin bad++; $display("FAIL ovf_last_key got=%h want=15", act_last); end
        cmd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (!act_valid && drop_cyc < 0) drop_cyc = i;
        end
        total++;
        if (pop_log.size() != 4 || pop_log[0] !== 3'd2 || pop_log[1] !== 3'd3 ||
            pop_log[2] !== 3'd4 || pop_log[3] !== 3'd5) begin
            bad++; $display("FAIL drain_order got=%p want=2,3,4,5", pop_log);
        end
        total++; if (drop_cyc != 4) begin bad++; $display("FAIL drain_valid_drop got=%0d want=4", drop_cyc); end
    endtask

    task automatic test_full_push_pop();
        clear_logs();
        cmd_ready = 1'b0;
        send(K_LEFT, 10);
        send(K_RIGHT, 10);
        send(K_SOFT, 10);
        send(K_RESTART, 10);
        data = {~K_LEFT, K_LEFT, CODE};
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        tick();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        repeat (4) tick();
        total++; if (ovf_count != 0) begin bad++; $display("FAIL pushpop_ovf got=%0d want=0", ovf_count); end
        cmd_ready = 1'b1;
        repeat (8) tick();
        total++;
        if (pop_log.size() != 5 || pop_log[0] !== 3'd1 || pop_log[1] !== 3'd2 || pop_log[2] !== 3'd4 ||
            pop_log[3] !== 3'd7 || pop_log[4] !== 3'd1) begin
            bad++; $display("FAIL pushpop_order got=%p want=1,2,4,7,1", pop_log);
        end
    endtask

    task automatic test_mid_reset();
        clear_logs();
        cmd_ready = 1'b0;
        send(K_RIGHT, 10);
        send(K_SOFT, 10);
        total++; if (act_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid got=%b want=1", act_valid); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", cmd_valid); end
        total++; if (cmd !== 3'd0) begin bad++; $display("FAIL midrst_cmd got=%0d want=0", cmd); end
        total++; if (last_key !== 8'h00) begin bad++; $display("FAIL midrst_last_key got=%h want=00", last_key); end
        do_reset();
    endtask

    task automatic test_random();
        int phase_left = 0;
        logic high = 1'b0;
        logic [7:0] k;
        int errs = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (phase_left == 0) begin
                high = !high;
                if (high) begin
                    case ($urandom_range(0, 8))
                        0: k = K_LEFT;  1: k = K_RIGHT; 2: k = K_ROT;
                        3: k = K_SOFT;  4: k = K_HARD;  5: k = K_PAUSE;
                        6: k = K_RESTART;
                        default: k = 8'($urandom);
                    endcase
                    data = {~k, k, ($urandom_range(0, 7) == 0) ? 16'($urandom) : CODE};
                    phase_left = $urandom_range(1, 3);
                end else begin
                    phase_left = $urandom_range(3, 12);
                end
            end
            data_ready = high;
            cmd_ready = ($urandom_range(0, 2) != 0);
            phase_left--;
            tick();
            total++; if (act_valid !== exp_valid) begin bad++; errs++; if (errs < 10) $display("FAIL rnd_valid cyc=%0d got=%b want=%b", i, act_valid, exp_valid); end
            total++; if (act_cmd !== exp_cmd) begin bad++; errs++; if (errs < 10) $display("FAIL rnd_cmd cyc=%0d got=%0d want=%0d", i, act_cmd, exp_cmd); end
            total++; if (act_ovf !== exp_ovf) begin bad++; errs++; if (errs < 10) $display("FAIL rnd_ovf cyc=%0d got=%b want=%b", i, act_ovf, exp_ovf); end
            total++; if (act_err !== exp_err) begin bad++; errs++; if (errs < 10) $display("FAIL rnd_addr_err cyc=%0d got=%b want=%b", i, act_err, exp_err); end
            total++; if (act_last !== exp_last) begin bad++; errs++; if (errs < 10) $display("FAIL rnd_last_key cyc=%0d got=%h want=%h", i, act_last, exp_last); end
        end
        data_ready = 1'b0;
    endtask

    initial begin
        model_reset();
        clear_logs();
        test_reset();
        test_single_hold();
        test_addr();
        test_lockout();
        test_repeat();
        test_overflow();
        test_full_push_pop();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
